// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice: bus widths, the "no producer"
// lock tag and the functional-unit requester IDs.
package cdb_arbiter_pkg;

  localparam int unsigned Data_Width     = 32;
  localparam int unsigned Reg_Lock_Width = 5;
  localparam int unsigned Reg_No_Lock    = 0;

  typedef enum int unsigned {
    REQ_ALU = 0,
    REQ_BRA = 1,
    REQ_LS  = 2,
    REQ_MUL = 3
  } req_id_e;

  localparam int unsigned NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of
// eligible at or after rr_ptr (wrapping), as one-hot and as an index.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  int unsigned   pos;
  logic [PW-1:0] p;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    p         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // modulo by subtraction keeps the wrap correct for non-power-of-2 N
      pos = 32'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      p = PW'(pos);
      if (!grant_any && eligible[p]) begin
        grant[p]  = 1'b1;
        grant_idx = p;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin one-hot grant, registered broadcast.
// Optional per-requester grant / idle statistics under CDB_ARB_STATS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned       LOCK_W  = Reg_Lock_Width,
  parameter int unsigned       DATA_W  = Data_Width,
  parameter logic [LOCK_W-1:0] NO_LOCK = LOCK_W'(Reg_No_Lock)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*LOCK_W-1:0]   req_index,
  input  logic [NUM_REQ*DATA_W-1:0]   req_result,
  output logic [NUM_REQ-1:0]          grnt,
  output logic                        cdb_out_valid,
  output logic [LOCK_W-1:0]           cdb_out_index,
  output logic [DATA_W-1:0]           cdb_out_result
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt,
  output logic [15:0]                 idle_cnt
`endif
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               blocked;
  logic               win;
  logic [PW-1:0]      next_ptr;
  logic [LOCK_W-1:0]  win_index;
  logic [DATA_W-1:0]  win_result;

  // a NO_LOCK tag means "no producer", so such a request is simply not eligible
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = req_valid[i] && (req_index[i*LOCK_W +: LOCK_W] != NO_LOCK);
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  always_comb begin
    blocked    = rst | flush;
    grnt       = blocked ? '0 : pick_grant;
    win        = !blocked && pick_any;
    win_index  = req_index[pick_idx*LOCK_W +: LOCK_W];
    win_result = req_result[pick_idx*DATA_W +: DATA_W];
    next_ptr   = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      cdb_out_valid  <= 1'b0;
      cdb_out_index  <= NO_LOCK;
      cdb_out_result <= '0;
    end else if (win) begin
      rr_ptr         <= next_ptr;
      cdb_out_valid  <= 1'b1;
      cdb_out_index  <= win_index;
      cdb_out_result <= win_result;
    end else begin
      cdb_out_valid  <= 1'b0;
      cdb_out_index  <= NO_LOCK;
      cdb_out_result <= '0;
    end
  end

`ifdef CDB_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gcnt
    always_ff @(posedge clk) begin
      if (rst)
        grant_cnt[i*16 +: 16] <= '0;
      else if (grnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
    end
  end

  // flush cycles carry no grant and therefore count as idle
  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (!win && idle_cnt != 16'hFFFF)
      idle_cnt <= idle_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table plus randomized
// traffic against a behavioural model (stats checked when CDB_ARB_STATS_EN).
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_index;
  logic [N*DW-1:0] req_result;
  logic [N-1:0]    grnt;
  logic            cdb_out_valid;
  logic [LW-1:0]   cdb_out_index;
  logic [DW-1:0]   cdb_out_result;
`ifdef CDB_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     idle_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ (N),
    .LOCK_W  (LW),
    .DATA_W  (DW),
    .NO_LOCK (5'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_index      (req_index),
    .req_result     (req_result),
    .grnt           (grnt),
    .cdb_out_valid  (cdb_out_valid),
    .cdb_out_index  (cdb_out_index),
    .cdb_out_result (cdb_out_result)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .idle_cnt       (idle_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          m_ptr;
  logic        m_cv;
  logic [4:0]  m_ci;
  logic [31:0] m_cr;
  int          m_gcnt [N];
  int          m_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // winner = eligible requester with smallest rotational distance from m_ptr
  function automatic int model_winner();
    int best  = -1;
    int bestd = N;
    if (rst || flush) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_index[i*LW +: LW] != 5'd0) begin
        int d = (i - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge(input int w);
    if (rst) begin
      m_ptr = 0; m_cv = 1'b0; m_ci = '0; m_cr = '0; m_idle = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else if (w >= 0) begin
      m_cv = 1'b1;
      m_ci = req_index[w*LW +: LW];
      m_cr = req_result[w*DW +: DW];
      m_ptr = (w + 1) % N;
      if (m_gcnt[w] < 65535) m_gcnt[w]++;
    end else begin
      m_cv = 1'b0; m_ci = '0; m_cr = '0;
      if (m_idle < 65535) m_idle++;
    end
  endtask

  task automatic model_check(input string tag);
    int w;
    logic [3:0] eg;
    w  = model_winner();
    eg = (w >= 0) ? 4'(1 << w) : 4'b0;
    chk({tag, "_grnt"}, 64'(grnt), 64'(eg));
    chk({tag, "_cv"},   64'(cdb_out_valid),  64'(m_cv));
    chk({tag, "_ci"},   64'(cdb_out_index),  64'(m_ci));
    chk({tag, "_cr"},   64'(cdb_out_result), 64'(m_cr));
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk({tag, "_gcnt"}, 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
    chk({tag, "_idle"}, 64'(idle_cnt), 64'(m_idle));
`endif
  endtask

  // advance one clock, updating the model with the inputs seen at the edge
  task automatic tick();
    int w;
    w = model_winner();
    @(posedge clk);
    model_edge(w);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       f;
    logic [3:0] v;
    logic       z0;
    logic [3:0] eg;
    int         src;
  } vec_t;

  vec_t        tbl [21];
  logic [4:0]  u_tag [N];
  logic [31:0] u_res [N];

  initial begin
    logic [3:0]  pend;
    logic [4:0]  r_tag [N];
    logic [31:0] r_res [N];
    int          w;

    u_tag = '{5'd5, 5'd6, 5'd7, 5'd8};
    u_res = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};

    tbl[0]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, -1};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    tbl[2]  = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, -1};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000,  2};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000, -1};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001,  3};
    tbl[6]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010,  0};
    tbl[7]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100,  1};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000,  2};
    tbl[9]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001,  3};
    tbl[10] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010,  0};
    tbl[11] = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000,  1};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    tbl[13] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, -1};
    tbl[14] = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0001,  2};
    tbl[15] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010,  0};
    tbl[16] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000,  1};
    tbl[17] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, -1};
    tbl[18] = '{1'b0, 1'b0, 4'b1001, 1'b1, 4'b1000, -1};
    tbl[19] = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000,  3};
    tbl[20] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, -1};

    m_ptr = 0; m_cv = 1'b0; m_ci = '0; m_cr = '0; m_idle = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;

    rst = 1'b1; flush = 1'b0; req_valid = '0; req_index = '0; req_result = '0;
    tick();

    // directed table
    for (int t = 0; t < 21; t++) begin
      rst       = tbl[t].r;
      flush     = tbl[t].f;
      req_valid = tbl[t].v;
      for (int i = 0; i < N; i++) begin
        req_index[i*LW +: LW]  = (i == 0 && tbl[t].z0) ? 5'd0 : u_tag[i];
        req_result[i*DW +: DW] = u_res[i];
      end
      #4;
      chk("tbl_grnt", 64'(grnt), 64'(tbl[t].eg));
      chk("tbl_cv", 64'(cdb_out_valid), 64'(tbl[t].src >= 0));
      chk("tbl_ci", 64'(cdb_out_index), (tbl[t].src >= 0) ? 64'(u_tag[tbl[t].src]) : 64'd0);
      chk("tbl_cr", 64'(cdb_out_result), (tbl[t].src >= 0) ? 64'(u_res[tbl[t].src]) : 64'd0);
`ifdef CDB_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("tbl_gcnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
      chk("tbl_idle", 64'(idle_cnt), 64'(m_idle));
`endif
      tick();
    end

    // randomized traffic; requests hold until the model grants them
    pend = '0;
    for (int i = 0; i < N; i++) begin r_tag[i] = '0; r_res[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 6);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && r_tag[i] == 5'd0 && $urandom_range(0, 9) < 3) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 9) < 5) begin
          pend[i]  = 1'b1;
          r_tag[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          r_res[i] = $urandom;
        end
        req_index[i*LW +: LW]  = r_tag[i];
        req_result[i*DW +: DW] = r_res[i];
      end
      req_valid = pend;
      #4;
      model_check("rnd");
      w = model_winner();
      tick();
      if (w >= 0) pend[w] = 1'b0;
      if (flush && $urandom_range(0, 1) == 1) pend = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
